// File: rtl/usb_ep_pkg.sv
// usb_ep_pkg: shared constants and types for the USB endpoint FIFO bank.
package usb_ep_pkg;
    localparam int EP_FIFO_DEPTH_LOG2_DEFAULT = 6;
    typedef logic [EP_FIFO_DEPTH_LOG2_DEFAULT:0] ep_fifo_ptr_t;
    // Which side of a FIFO carries the committed/tentative pointer pair.
    typedef enum logic {TRANS_READ, TRANS_WRITE} trans_side_e;
endpackage

// File: rtl/usb_ep_fifo_bank_if.sv
// usb_ep_fifo_bank_if: application and protocol-engine signals of the endpoint FIFO bank.
// Each vector holds one bit per endpoint; data buses hold EP_DATA_WID bits per endpoint.
// Modport master drives the app/PE requests, modport slave is the FIFO bank.
interface usb_ep_fifo_bank_if #(
    parameter int EP_COUNT    = 2,
    parameter int EP_DATA_WID = 8
);
    logic [EP_COUNT-1:0]             app_in_write_i;
    logic [EP_DATA_WID*EP_COUNT-1:0] app_in_data_i;
    logic [EP_COUNT-1:0]             app_in_full_o;
    logic [EP_COUNT-1:0]             pe_in_pop_i;
    logic [EP_COUNT-1:0]             pe_in_popTransDone_i;
    logic [EP_COUNT-1:0]             pe_in_popTransSuccess_i;
    logic [EP_COUNT-1:0]             pe_in_dataAvailable_o;
    logic [EP_DATA_WID*EP_COUNT-1:0] pe_in_data_o;
    logic [EP_COUNT-1:0]             pe_out_dataValid_i;
    logic [EP_DATA_WID*EP_COUNT-1:0] pe_out_data_i;
    logic [EP_COUNT-1:0]             pe_out_fillTransDone_i;
    logic [EP_COUNT-1:0]             pe_out_fillTransSuccess_i;
    logic [EP_COUNT-1:0]             pe_out_full_o;
    logic [EP_COUNT-1:0]             app_out_read_i;
    logic [EP_COUNT-1:0]             app_out_valid_o;
    logic [EP_DATA_WID*EP_COUNT-1:0] app_out_data_o;

    modport master (
        output app_in_write_i, app_in_data_i, pe_in_pop_i, pe_in_popTransDone_i,
               pe_in_popTransSuccess_i, pe_out_dataValid_i, pe_out_data_i,
               pe_out_fillTransDone_i, pe_out_fillTransSuccess_i, app_out_read_i,
        input  app_in_full_o, pe_in_dataAvailable_o, pe_in_data_o, pe_out_full_o,
               app_out_valid_o, app_out_data_o
    );

    modport slave (
        input  app_in_write_i, app_in_data_i, pe_in_pop_i, pe_in_popTransDone_i,
               pe_in_popTransSuccess_i, pe_out_dataValid_i, pe_out_data_i,
               pe_out_fillTransDone_i, pe_out_fillTransSuccess_i, app_out_read_i,
        output app_in_full_o, pe_in_dataAvailable_o, pe_in_data_o, pe_out_full_o,
               app_out_valid_o, app_out_data_o
    );
endinterface

// File: rtl/usb_trans_fifo.sv
// usb_trans_fifo: single FIFO whose read or write side is transactional (commit/rewind).
// Ports: clk_i, rst_n_i (async, active low), flush_i (sync clear), wr_i/wr_data_i/full_o write side,
// rd_i/avail_o/rd_data_o read side (first-word fall-through), done_i/success_i transaction end.
module usb_trans_fifo
    import usb_ep_pkg::*;
#(
    parameter trans_side_e TRANS_SIDE = TRANS_READ,
    parameter int          W          = 8,
    parameter int          DEPTH_LOG2 = EP_FIFO_DEPTH_LOG2_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_data_i,
    output logic         full_o,
    input  logic         rd_i,
    input  logic         done_i,
    input  logic         success_i,
    output logic         avail_o,
    output logic [W-1:0] rd_data_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam bit TX_RD = (TRANS_SIDE == TRANS_READ);
    typedef logic [DEPTH_LOG2:0] ptr_t;

    // The non-transactional side keeps its "committed" copy equal to its tentative pointer,
    // so the same full/avail equations serve both flavours.
    ptr_t wtent_q, wtent_d, wcom_q, wcom_d, rtent_q, rtent_d, rcom_q, rcom_d;
    logic ovf_q, ovf_d, ovf_now, commit, rewind, wr_ok, rd_ok;
    logic [W-1:0] mem_q [DEPTH];

    assign full_o    = (wtent_q - rcom_q) == ptr_t'(DEPTH);
    assign avail_o   = rtent_q != wcom_q;
    assign rd_data_o = mem_q[rtent_q[DEPTH_LOG2-1:0]];

    always_comb begin
        // A byte dropped in the TransDone cycle itself also spoils the packet.
        ovf_now = !TX_RD && (ovf_q || (wr_i && full_o));
        commit  = done_i && success_i && !ovf_now;
        rewind  = done_i && !commit;
        wr_ok   = wr_i && !full_o;
        rd_ok   = rd_i && avail_o && !(TX_RD && rewind);
        wtent_d = (!TX_RD && rewind) ? wcom_q : wtent_q + ptr_t'(wr_ok);
        wcom_d  = (TX_RD || commit) ? wtent_d : wcom_q;
        rtent_d = (TX_RD && rewind) ? rcom_q : rtent_q + ptr_t'(rd_ok);
        rcom_d  = (!TX_RD || commit) ? rtent_d : rcom_q;
        ovf_d   = done_i ? 1'b0 : ovf_now;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i || flush_i) begin
            wtent_q <= '0;
            wcom_q  <= '0;
            rtent_q <= '0;
            rcom_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wtent_q <= wtent_d;
            wcom_q  <= wcom_d;
            rtent_q <= rtent_d;
            rcom_q  <= rcom_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wtent_q[DEPTH_LOG2-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/usb_ep_fifo_bank.sv
// usb_ep_fifo_bank: one transactional IN FIFO and one transactional OUT FIFO per non-control endpoint.
// Ports: clk48_i sole clock, rst_n_i async active-low reset, usbReset_i sync flush of every FIFO,
// bus (slave modport) carrying the per-endpoint app/PE handshakes and data slices [k*W +: W].
module usb_ep_fifo_bank
    import usb_ep_pkg::*;
#(
    parameter int EP_COUNT    = 2,
    parameter int EP_DATA_WID = 8,
    parameter int DEPTH_LOG2  = EP_FIFO_DEPTH_LOG2_DEFAULT
) (
    input logic               clk48_i,
    input logic               rst_n_i,
    input logic               usbReset_i,
    usb_ep_fifo_bank_if.slave bus
);
    localparam int W = EP_DATA_WID;

    for (genvar k = 0; k < EP_COUNT; k++) begin : g_ep
        // IN: application writes, PE pops transactionally.
        usb_trans_fifo #(.TRANS_SIDE(TRANS_READ), .W(W), .DEPTH_LOG2(DEPTH_LOG2)) u_in (
            .clk_i    (clk48_i),
            .rst_n_i  (rst_n_i),
            .flush_i  (usbReset_i),
            .wr_i     (bus.app_in_write_i[k]),
            .wr_data_i(bus.app_in_data_i[k*W +: W]),
            .full_o   (bus.app_in_full_o[k]),
            .rd_i     (bus.pe_in_pop_i[k]),
            .done_i   (bus.pe_in_popTransDone_i[k]),
            .success_i(bus.pe_in_popTransSuccess_i[k]),
            .avail_o  (bus.pe_in_dataAvailable_o[k]),
            .rd_data_o(bus.pe_in_data_o[k*W +: W])
        );
        // OUT: PE fills transactionally, application reads committed data.
        usb_trans_fifo #(.TRANS_SIDE(TRANS_WRITE), .W(W), .DEPTH_LOG2(DEPTH_LOG2)) u_out (
            .clk_i    (clk48_i),
            .rst_n_i  (rst_n_i),
            .flush_i  (usbReset_i),
            .wr_i     (bus.pe_out_dataValid_i[k]),
            .wr_data_i(bus.pe_out_data_i[k*W +: W]),
            .full_o   (bus.pe_out_full_o[k]),
            .rd_i     (bus.app_out_read_i[k]),
            .done_i   (bus.pe_out_fillTransDone_i[k]),
            .success_i(bus.pe_out_fillTransSuccess_i[k]),
            .avail_o  (bus.app_out_valid_o[k]),
            .rd_data_o(bus.app_out_data_o[k*W +: W])
        );
    end
endmodule

// File: tb/tb_usb_ep_fifo_bank.sv
// tb_usb_ep_fifo_bank: directed and random stimulus checked against a queue-based model.
module tb_usb_ep_fifo_bank;
    localparam int N = 2, W = 8, DL = 3, D = 8;

    logic clk = 1'b0, rst_n = 1'b0, usb_reset = 1'b0;
    always #5 clk = ~clk;

    usb_ep_fifo_bank_if #(.EP_COUNT(N), .EP_DATA_WID(W)) bus ();

    usb_ep_fifo_bank #(.EP_COUNT(N), .EP_DATA_WID(W), .DEPTH_LOG2(DL)) dut (
        .clk48_i   (clk),
        .rst_n_i   (rst_n),
        .usbReset_i(usb_reset),
        .bus       (bus.slave)
    );

    // IN model: stored entries not yet committed-read, with a count of tentatively popped ones.
    // OUT model: committed packet bytes, the current tentative packet, and its overflow flag.
    logic [7:0] inq [N][$];
    int         ipend [N];
    logic [7:0] oc [N][$];
    logic [7:0] ot [N][$];
    bit         ovf [N];
    int vectors = 0, miscompares = 0;

    task automatic chk1(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.app_in_write_i = '0; bus.app_in_data_i = '0;
        bus.pe_in_pop_i = '0; bus.pe_in_popTransDone_i = '0; bus.pe_in_popTransSuccess_i = '0;
        bus.pe_out_dataValid_i = '0; bus.pe_out_data_i = '0;
        bus.pe_out_fillTransDone_i = '0; bus.pe_out_fillTransSuccess_i = '0;
        bus.app_out_read_i = '0;
        usb_reset = 1'b0;
    endtask

    task automatic model_flush();
        for (int e = 0; e < N; e++) begin
            inq[e].delete(); oc[e].delete(); ot[e].delete();
            ipend[e] = 0; ovf[e] = 0;
        end
    endtask

    task automatic model_step();
        if (!rst_n || usb_reset) begin
            model_flush();
            return;
        end
        for (int e = 0; e < N; e++) begin
            bit ifull, iav, idone, isucc, ofull, oov, dv;
            ifull = inq[e].size() == D;
            iav   = ipend[e] < inq[e].size();
            idone = bus.pe_in_popTransDone_i[e];
            isucc = bus.pe_in_popTransSuccess_i[e];
            if (bus.pe_in_pop_i[e] && iav && !(idone && !isucc)) ipend[e]++;
            if (idone) begin
                if (isucc) repeat (ipend[e]) void'(inq[e].pop_front());
                ipend[e] = 0;
            end
            if (bus.app_in_write_i[e] && !ifull) inq[e].push_back(bus.app_in_data_i[e*W +: W]);
            dv    = bus.pe_out_dataValid_i[e];
            ofull = (oc[e].size() + ot[e].size()) == D;
            oov   = ovf[e] || (dv && ofull);
            if (bus.app_out_read_i[e] && oc[e].size() > 0) void'(oc[e].pop_front());
            if (dv && !ofull) ot[e].push_back(bus.pe_out_data_i[e*W +: W]);
            if (bus.pe_out_fillTransDone_i[e]) begin
                if (bus.pe_out_fillTransSuccess_i[e] && !oov) foreach (ot[e][i]) oc[e].push_back(ot[e][i]);
                ot[e].delete();
                ovf[e] = 0;
            end else ovf[e] = oov;
        end
    endtask

    task automatic check_all();
        for (int e = 0; e < N; e++) begin
            bit av;
            av = ipend[e] < inq[e].size();
            chk1($sformatf("ep%0d app_in_full", e), bus.app_in_full_o[e], inq[e].size() == D);
            chk1($sformatf("ep%0d pe_in_avail", e), bus.pe_in_dataAvailable_o[e], av);
            if (av) chk8($sformatf("ep%0d pe_in_data", e), bus.pe_in_data_o[e*W +: W], inq[e][ipend[e]]);
            chk1($sformatf("ep%0d pe_out_full", e), bus.pe_out_full_o[e], (oc[e].size() + ot[e].size()) == D);
            chk1($sformatf("ep%0d app_out_valid", e), bus.app_out_valid_o[e], oc[e].size() > 0);
            if (oc[e].size() > 0) chk8($sformatf("ep%0d app_out_data", e), bus.app_out_data_o[e*W +: W], oc[e][0]);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        clear_inputs();
        check_all();
    endtask

    task automatic in_wr(int e, logic [7:0] d);
        bus.app_in_write_i[e] = 1'b1; bus.app_in_data_i[e*W +: W] = d;
    endtask
    task automatic in_pop(int e);
        bus.pe_in_pop_i[e] = 1'b1;
    endtask
    task automatic in_done(int e, logic s);
        bus.pe_in_popTransDone_i[e] = 1'b1; bus.pe_in_popTransSuccess_i[e] = s;
    endtask
    task automatic out_fill(int e, logic [7:0] d);
        bus.pe_out_dataValid_i[e] = 1'b1; bus.pe_out_data_i[e*W +: W] = d;
    endtask
    task automatic out_done(int e, logic s);
        bus.pe_out_fillTransDone_i[e] = 1'b1; bus.pe_out_fillTransSuccess_i[e] = s;
    endtask
    task automatic out_rd(int e);
        bus.app_out_read_i[e] = 1'b1;
    endtask

    task automatic flags_zero(string tag);
        chk8({tag, " in_full"}, 8'(bus.app_in_full_o), 8'h0);
        chk8({tag, " in_avail"}, 8'(bus.pe_in_dataAvailable_o), 8'h0);
        chk8({tag, " out_full"}, 8'(bus.pe_out_full_o), 8'h0);
        chk8({tag, " out_valid"}, 8'(bus.app_out_valid_o), 8'h0);
    endtask

    initial begin
        logic [7:0] seq [3];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        clear_inputs();
        model_flush();
        #2;
        flags_zero("reset");
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        flags_zero("post_reset");

        // IN retry on EP0
        for (int i = 0; i < 3; i++) begin in_wr(0, seq[i]); cycle(); end
        repeat (3) begin in_pop(0); cycle(); end
        chk1("retry popped_avail", bus.pe_in_dataAvailable_o[0], 1'b0);
        in_done(0, 1'b0); cycle();
        chk1("retry avail", bus.pe_in_dataAvailable_o[0], 1'b1);
        chk8("retry data", bus.pe_in_data_o[7:0], 8'h11);
        in_pop(0); cycle();
        in_pop(0); cycle();
        in_pop(0); in_done(0, 1'b1); cycle();
        chk1("retry commit avail", bus.pe_in_dataAvailable_o[0], 1'b0);
        chk1("retry commit full", bus.app_in_full_o[0], 1'b0);

        // IN full/commit on EP1
        for (int i = 0; i < D; i++) begin in_wr(1, 8'(8'h40 + i)); cycle(); end
        chk1("in1 full", bus.app_in_full_o[1], 1'b1);
        in_wr(1, 8'hFF); cycle();
        chk8("in1 head after drop", bus.pe_in_data_o[15:8], 8'h40);
        repeat (D) begin in_pop(1); cycle(); end
        chk1("in1 full uncommitted", bus.app_in_full_o[1], 1'b1);
        in_done(1, 1'b1); cycle();
        chk1("in1 full after commit", bus.app_in_full_o[1], 1'b0);

        // OUT commit/discard on EP0
        for (int i = 0; i < 4; i++) begin out_fill(0, 8'(8'hA0 + i)); cycle(); end
        chk1("out uncommitted valid", bus.app_out_valid_o[0], 1'b0);
        out_done(0, 1'b1); cycle();
        chk8("out first", bus.app_out_data_o[7:0], 8'hA0);
        repeat (4) begin out_rd(0); cycle(); end
        out_fill(0, 8'hB0); cycle();
        out_fill(0, 8'hB1); cycle();
        out_done(0, 1'b0); cycle();
        chk1("out discard valid", bus.app_out_valid_o[0], 1'b0);

        // OUT overflow on EP0
        for (int i = 0; i < D + 1; i++) begin
            out_fill(0, 8'(8'hC0 + i)); cycle();
            if (i == D - 1) chk1("out full after 8", bus.pe_out_full_o[0], 1'b1);
        end
        out_done(0, 1'b1); cycle();
        chk1("ovf discarded valid", bus.app_out_valid_o[0], 1'b0);
        chk1("ovf discarded full", bus.pe_out_full_o[0], 1'b0);
        out_fill(0, 8'hD0); cycle();
        out_fill(0, 8'hD1); out_done(0, 1'b1); cycle();
        chk8("after ovf data", bus.app_out_data_o[7:0], 8'hD0);
        repeat (2) begin out_rd(0); cycle(); end

        // Concurrent wrapping transactions, pop and byte in the TransDone cycle
        for (int t = 0; t < 20; t++) begin
            for (int j = 0; j < 3; j++) begin
                for (int e = 0; e < N; e++) begin
                    in_wr(e, 8'(t * 3 + j + e * 128));
                    out_fill(e, 8'(t * 5 + j + e * 64));
                    if (j == 2) out_done(e, 1'b1);
                end
                cycle();
            end
            for (int j = 0; j < 3; j++) begin
                for (int e = 0; e < N; e++) begin
                    in_pop(e);
                    if (j == 2) in_done(e, 1'b1);
                    out_rd(e);
                end
                cycle();
            end
        end
        flags_zero("wrap drained");

        // Synchronous flush mid-transaction, with competing inputs in the same cycle
        in_wr(0, 8'h71); out_fill(1, 8'h81); cycle();
        in_wr(0, 8'h72); out_fill(1, 8'h82); cycle();
        in_pop(0); out_done(1, 1'b1); cycle();
        usb_reset = 1'b1; in_wr(0, 8'h73); out_fill(1, 8'h83); in_pop(0); cycle();
        flags_zero("usb_reset");
        in_wr(0, 8'h5A); cycle();
        chk8("after flush data", bus.pe_in_data_o[7:0], 8'h5A);

        // Asynchronous reset mid-transaction, checked before any clock edge
        out_fill(0, 8'h91); in_wr(1, 8'h92); cycle();
        in_pop(0); cycle();
        rst_n = 1'b0;
        model_flush();
        #1;
        flags_zero("async_reset");
        @(posedge clk);
        #1;
        flags_zero("async_reset held");
        rst_n = 1'b1;
        in_wr(1, 8'h6B); cycle();
        chk8("after reset data", bus.pe_in_data_o[15:8], 8'h6B);

        // Random traffic on both endpoints
        for (int c = 0; c < 800; c++) begin
            for (int e = 0; e < N; e++) begin
                if ($urandom_range(0, 99) < 50) in_wr(e, 8'($urandom));
                if ($urandom_range(0, 99) < 45) in_pop(e);
                if ($urandom_range(0, 99) < 12) in_done(e, 1'($urandom));
                if ($urandom_range(0, 99) < 45) out_fill(e, 8'($urandom));
                if ($urandom_range(0, 99) < 12) out_done(e, $urandom_range(0, 99) < 70);
                if ($urandom_range(0, 99) < 40) out_rd(e);
            end
            if ($urandom_range(0, 299) == 0) usb_reset = 1'b1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/usb_ep_fifo_bank.md
Name: usb_ep_fifo_bank

Overview:
Parametrised bank of per-endpoint transactional FIFOs that drives the endpoint interfaces of usb_pe, which the current top level leaves undriven.
- Each non-control endpoint gets one IN FIFO: the application writes it, and the PE pops it transactionally.
- Each non-control endpoint gets one OUT FIFO: the PE fills it transactionally, and the application reads it.
- Transactions commit on success or rewind on failure, which supports USB retransmission (NAK/timeout/CRC error).
- Sits between usb_pe and the application in the usb top level, in the clk48_i domain.

Parameters:
- EP_COUNT, 2, number of non-control endpoints (USB_DEV_EP_CONF.endpointCount); each gets one IN and one OUT FIFO.
- EP_DATA_WID, 8, data width per entry.
- DEPTH_LOG2, 6, log2 of entries per FIFO; range 2..10.

Ports:
- clk48_i  in  1  48 MHz clock; sole clock.
- rst_n_i  in  1  Asynchronous active-low reset.
- usbReset_i  in  1  Synchronous flush of all FIFOs; one cycle is sufficient.
- app_in_write_i  in  EP_COUNT  Application pushes one entry per endpoint.
- app_in_data_i  in  EP_DATA_WID*EP_COUNT  Write data; endpoint k occupies bits [k*W +: W].
- app_in_full_o  out  EP_COUNT  IN FIFO full, measured against the committed read pointer.
- pe_in_pop_i  in  EP_COUNT  PE consumes the current entry (tentative).
- pe_in_popTransDone_i  in  EP_COUNT  End of an IN transaction.
- pe_in_popTransSuccess_i  in  EP_COUNT  Sampled with TransDone: 1 = commit, 0 = rewind.
- pe_in_dataAvailable_o  out  EP_COUNT  Uncommitted-read data present.
- pe_in_data_o  out  EP_DATA_WID*EP_COUNT  First-word-fall-through data at the tentative read pointer.
- pe_out_dataValid_i  in  EP_COUNT  PE writes one entry (tentative).
- pe_out_data_i  in  EP_DATA_WID*EP_COUNT  Fill data.
- pe_out_fillTransDone_i  in  EP_COUNT  End of an OUT transaction.
- pe_out_fillTransSuccess_i  in  EP_COUNT  Sampled with TransDone: 1 = commit, 0 = discard.
- pe_out_full_o  out  EP_COUNT  Tentative write pointer has reached capacity.
- app_out_read_i  in  EP_COUNT  Application consumes one committed entry.
- app_out_valid_o  out  EP_COUNT  Committed data present.
- app_out_data_o  out  EP_DATA_WID*EP_COUNT  First-word-fall-through data at the read pointer.

Behaviour:
- Pointers:
  - Each FIFO holds pointers of DEPTH_LOG2+1 bits that wrap modulo 2^(DEPTH_LOG2+1); the memory is indexed by the low DEPTH_LOG2 bits.
  - IN FIFO: wptr, rptrTent, rptrCommit.
  - OUT FIFO: wptrTent, wptrCommit, rptr, plus an overflow flag.
- Flag equations:
  - IN full = (wptr - rptrCommit) == DEPTH.
  - IN dataAvailable = (rptrTent != wptr).
  - OUT full = (wptrTent - rptr) == DEPTH.
  - OUT valid = (rptr != wptrCommit).
- Reset (rst_n_i low, asynchronous):
  - All pointers and the overflow flag are cleared.
  - full, dataAvailable and valid outputs are 0.
  - The memory is not reset; data outputs are don't-care while their valid/available flag is low.
- usbReset_i: the same clearing happens synchronously, and it has priority over every other input in that cycle.
- Latency:
  - A write becomes visible on the cycle after the write or commit edge.
  - Data outputs are combinational reads of the register array (first-word fall-through).
- IN pop side:
  - pop with dataAvailable: rptrTent increments.
  - pop while empty: ignored.
  - TransDone with Success=1: rptrCommit := rptrTent, including a pop in the same cycle.
  - TransDone with Success=0: rptrTent := rptrCommit, and a same-cycle pop is ignored.
- IN write side:
  - app write when not full: entry stored at wptr, wptr increments.
  - app write when full: dropped.
  - Write and pop in the same cycle are both applied.
- OUT fill side:
  - dataValid when not full: entry stored at wptrTent, wptrTent increments.
  - dataValid when full: byte dropped, and the overflow flag is set for the current transaction.
  - TransDone with Success=1 and no overflow: wptrCommit := wptrTent, including a same-cycle byte.
  - TransDone with Success=0, or with overflow set: wptrTent := wptrCommit, so the whole packet is discarded.
  - The overflow flag clears on every TransDone.
- OUT read side:
  - app read when valid: rptr increments.
  - app read when empty: ignored.
  - Reads never touch uncommitted data.
- A TransDone without any prior pop or fill is a no-op commit/rewind.
- Endpoints are fully independent; there is no arbitration.

Decomposition:
- usb_ep_pkg: add the constant EP_FIFO_DEPTH_LOG2_DEFAULT, plus typedef ep_fifo_ptr_t parameterised by DEPTH_LOG2 via a macro or localparam.
- Sub-module usb_trans_fifo:
  - One FIFO with a generic committed/tentative pointer on a selectable side, via parameter TRANS_SIDE (READ/WRITE).
  - Implements the pointer logic, the flags and the overflow flag.
- The bank is a generate loop over EP_COUNT that instantiates 2*EP_COUNT usb_trans_fifo and slices the packed vectors.

Test Plan:
All scenarios use EP_COUNT=2, DEPTH_LOG2=3, EP_DATA_WID=8.
- IN retry: app writes 0x11,0x22,0x33 to EP0 → PE pops 3 → TransDone with Success=0 → dataAvailable=1 and data=0x11 again → pop 3 with Success=1 → dataAvailable=0, full=0.
- IN full/commit: 8 writes to EP1 → full=1 and a 9th write (0xFF) is dropped → pop 8 uncommitted leaves full=1 → commit → full=0 on the next cycle.
- OUT commit/discard: PE fills 0xA0..0xA3 then commits → app reads 0xA0..0xA3 → PE fills 0xB0,0xB1 then fails → valid stays 0.
- OUT overflow: PE fills 9 bytes to EP0 (DEPTH=8) → pe_out_full_o=1 after the 8th → commit with Success=1 → discarded, valid=0; the next 2-byte packet commits normally.
- Simultaneous/wrap: 20 transactions of 3 bytes each drive pointers past the wrap; a pop in the same cycle as TransDone with Success=1 is counted; EP0 and EP1 run concurrently with independent data (no crosstalk).
- Reset/flush: mid-transaction, assert usbReset_i for one cycle, then repeat with rst_n_i low asynchronously (no clock) → all flags 0 immediately/next cycle; the FIFOs then behave as empty.
